// File: rtl/ksa_addsub_pipe.sv
// Pipelined Kogge-Stone add/subtract unit. One register stage for precompute,
// one per prefix level and one for the sum/flags, with valid/ready flow control.
module ksa_addsub_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cb,
  output logic         ovf,
  output logic         zero
);

  localparam int D = $clog2(N);
  localparam int L = D + 2;

  // Stage valid bits: 0 = precompute, 1..D = prefix levels, L-1 = sum.
  logic [L-1:0] r_v;
  logic [L-1:0] w_adv;

  // Per-stage group propagate/generate, original propagate and side-band bits.
  logic [N-1:0] r_p  [0:D];
  logic [N-1:0] r_g  [0:D];
  logic [N-1:0] r_p0 [0:D];
  logic [D:0]   r_cin;
  logic [D:0]   r_am;
  logic [D:0]   r_bm;

  logic [N-1:0] r_s;
  logic         r_cb;
  logic         r_ovf;
  logic         r_zero;

  logic [N-1:0]        w_bb;
  logic [N-1:0]        w_p_in;
  logic [N-1:0]        w_g_in;
  logic                w_gc0;
  logic [D:1][N-1:0]   w_p;
  logic [D:1][N-1:0]   w_g;
  logic [N-1:0]        w_carry;
  logic [N-1:0]        w_s;
  logic                w_c;
  logic                w_ovf;

  // A stage may hand its contents on when the next stage is empty or leaving.
  always_comb begin
    w_adv        = '0;
    w_adv[L-1]   = out_ready;
    for (int j = L - 2; j >= 0; j--) begin
      w_adv[j] = ~r_v[j+1] | w_adv[j+1];
    end
  end

  assign in_ready = ~r_v[0] | w_adv[0];

  assign w_bb   = op ? ~b : b;
  assign w_p_in = a ^ w_bb;
  assign w_g_in = a & w_bb;

  // Carry-in is absorbed into bit 0 at level 1, so every later group that
  // reaches bit 0 already accounts for it and only needs a gray cell.
  assign w_gc0 = r_g[0][0] | (r_p[0][0] & r_cin[0]);

  genvar gr, gi;
  generate
    for (gr = 1; gr <= D; gr++) begin : g_lvl
      localparam int K = 1 << (gr - 1);
      for (gi = 0; gi < N; gi++) begin : g_bit
        if (gr == 1 && gi == 0) begin : g_cin
          assign w_g[gr][gi] = w_gc0;
          assign w_p[gr][gi] = r_p[gr-1][gi];
        end else if (gr == 1 && gi == 1) begin : g_gray1
          assign w_g[gr][gi] = r_g[gr-1][gi] | (r_p[gr-1][gi] & w_gc0);
          assign w_p[gr][gi] = r_p[gr-1][gi];
        end else if (gi >= 2 * K) begin : g_black
          assign w_g[gr][gi] = r_g[gr-1][gi] | (r_p[gr-1][gi] & r_g[gr-1][gi-K]);
          assign w_p[gr][gi] = r_p[gr-1][gi] & r_p[gr-1][gi-K];
        end else if (gi >= K) begin : g_gray
          assign w_g[gr][gi] = r_g[gr-1][gi] | (r_p[gr-1][gi] & r_g[gr-1][gi-K]);
          assign w_p[gr][gi] = r_p[gr-1][gi];
        end else begin : g_pass
          assign w_g[gr][gi] = r_g[gr-1][gi];
          assign w_p[gr][gi] = r_p[gr-1][gi];
        end
      end
    end
  endgenerate

  assign w_carry = {r_g[D][N-2:0], r_cin[D]};
  assign w_s     = r_p0[D] ^ w_carry;
  assign w_c     = r_g[D][N-1];
  assign w_ovf   = (r_am[D] == r_bm[D]) && (w_s[N-1] != r_am[D]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int j = 0; j <= D; j++) begin
        r_p[j]  <= '0;
        r_g[j]  <= '0;
        r_p0[j] <= '0;
      end
      r_cin  <= '0;
      r_am   <= '0;
      r_bm   <= '0;
      r_s    <= '0;
      r_cb   <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (in_ready) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_p[0]   <= w_p_in;
          r_g[0]   <= w_g_in;
          r_p0[0]  <= w_p_in;
          r_cin[0] <= op;
          r_am[0]  <= a[N-1];
          r_bm[0]  <= w_bb[N-1];
        end
      end
      for (int j = 1; j <= D; j++) begin
        if (w_adv[j-1]) begin
          r_v[j] <= r_v[j-1];
          if (r_v[j-1]) begin
            r_p[j]   <= w_p[j];
            r_g[j]   <= w_g[j];
            r_p0[j]  <= r_p0[j-1];
            r_cin[j] <= r_cin[j-1];
            r_am[j]  <= r_am[j-1];
            r_bm[j]  <= r_bm[j-1];
          end
        end
      end
      if (w_adv[D]) begin
        r_v[L-1] <= r_v[D];
        if (r_v[D]) begin
          r_s    <= w_s;
          r_cb   <= r_cin[D] ? ~w_c : w_c;
          r_ovf  <= w_ovf;
          r_zero <= ~|w_s;
        end
      end
    end
  end

  assign out_valid = r_v[L-1];
  assign s         = r_s;
  assign cb        = r_cb;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_ksa_addsub_pipe.sv
// Bench for ksa_addsub_pipe: directed vectors at N=8, random streams against an
// arithmetic reference model at N=8/4/32, stall, back-pressure and reset cases.
module tb_ksa_addsub_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  in_valid_d;
  logic [2:0]  op_d;
  logic [2:0]  out_ready_d;
  logic [31:0] a_d [3];
  logic [31:0] b_d [3];
  wire  [2:0]  ir, ov, cbw, ovw, zw;
  wire  [7:0]  s8;
  wire  [3:0]  s4;
  wire  [31:0] s32;

  ksa_addsub_pipe #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d[0]), .in_ready(ir[0]),
    .a(a_d[0][7:0]), .b(b_d[0][7:0]), .op(op_d[0]), .out_valid(ov[0]),
    .out_ready(out_ready_d[0]), .s(s8), .cb(cbw[0]), .ovf(ovw[0]), .zero(zw[0]));

  ksa_addsub_pipe #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d[1]), .in_ready(ir[1]),
    .a(a_d[1][3:0]), .b(b_d[1][3:0]), .op(op_d[1]), .out_valid(ov[1]),
    .out_ready(out_ready_d[1]), .s(s4), .cb(cbw[1]), .ovf(ovw[1]), .zero(zw[1]));

  ksa_addsub_pipe #(.N(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d[2]), .in_ready(ir[2]),
    .a(a_d[2]), .b(b_d[2]), .op(op_d[2]), .out_valid(ov[2]),
    .out_ready(out_ready_d[2]), .s(s32), .cb(cbw[2]), .ovf(ovw[2]), .zero(zw[2]));

  typedef struct {
    logic [31:0] s;
    bit          cb;
    bit          ovf;
    bit          zero;
  } res_t;

  typedef struct {
    bit         op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    bit         cb;
    bit         ovf;
    bit         zero;
  } vec_t;

  int checks = 0;
  int errors = 0;

  function automatic int wid(int n);
    case (n)
      0:       return 8;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] get_s(int n);
    case (n)
      0:       return {24'd0, s8};
      1:       return {28'd0, s4};
      default: return s32;
    endcase
  endfunction

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed readings.
  function automatic res_t model(int w, bit op, longint unsigned a, longint unsigned b);
    res_t r;
    longint unsigned full, mask;
    longint half, sa, sb, t;
    mask = (64'd1 << w) - 64'd1;
    half = longint'(64'd1 << (w - 1));
    if (op) begin
      full = a - b;
      r.cb = (a < b);
    end else begin
      full = a + b;
      r.cb = ((full >> w) != 0);
    end
    r.s    = 32'(full & mask);
    sa     = (a >= 64'(half)) ? longint'(a) - 2 * half : longint'(a);
    sb     = (b >= 64'(half)) ? longint'(b) - 2 * half : longint'(b);
    t      = op ? sa - sb : sa + sb;
    r.ovf  = (t < -half) || (t >= half);
    r.zero = (r.s == 32'd0);
    return r;
  endfunction

  // Scoreboard / monitor for the DUT currently under test (act_n).
  int      act_n = 0;
  bit      sb_en = 1'b0;
  res_t    exp_q[$];
  res_t    mon_e;
  int      n_acc = 0;
  int      n_pop = 0;
  int      cyc = 0;
  int      first_pop = 0;
  int      last_pop = 0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_s;
  bit          prev_cb, prev_ovf, prev_zero;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", ov[act_n], 1);
        chk("hold_s", get_s(act_n), prev_s);
        chk("hold_flags", {cbw[act_n], ovw[act_n], zw[act_n]}, {prev_cb, prev_ovf, prev_zero});
      end
      if (sb_en) begin
        if (in_valid_d[act_n] && ir[act_n]) begin
          exp_q.push_back(model(wid(act_n), op_d[act_n], a_d[act_n], b_d[act_n]));
          n_acc++;
        end
        if (ov[act_n] && out_ready_d[act_n]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: dut %0d s=0x%0h with no result pending", act_n, get_s(act_n));
          end else begin
            mon_e = exp_q.pop_front();
            chk("sb_s", get_s(act_n), mon_e.s);
            chk("sb_cb", cbw[act_n], mon_e.cb);
            chk("sb_ovf", ovw[act_n], mon_e.ovf);
            chk("sb_zero", zw[act_n], mon_e.zero);
            n_pop++;
            if (n_pop == 1) first_pop = cyc;
            last_pop = cyc;
            $display("dut%0d out #%0d s=0x%0h cb=%0b ovf=%0b zero=%0b", act_n, n_pop,
                     get_s(act_n), cbw[act_n], ovw[act_n], zw[act_n]);
          end
        end
      end
      prev_stall = ov[act_n] && !out_ready_d[act_n];
      prev_s     = get_s(act_n);
      prev_cb    = cbw[act_n];
      prev_ovf   = ovw[act_n];
      prev_zero  = zw[act_n];
    end
  end

  task automatic sb_start(int n);
    act_n = n;
    exp_q.delete();
    n_acc = 0;
    n_pop = 0;
    sb_en = 1'b1;
  endtask

  task automatic drive_rand(int n);
    longint unsigned mask;
    mask = (64'd1 << wid(n)) - 64'd1;
    in_valid_d[n] = 1'b1;
    a_d[n] = 32'($urandom) & 32'(mask);
    b_d[n] = 32'($urandom) & 32'(mask);
    op_d[n] = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(string name);
    int t;
    t = 0;
    while (n_pop < n_acc && t < 200) begin
      @(posedge clk);
      t++;
    end
    repeat (8) @(posedge clk);
    chk({name, "_drained"}, n_pop, n_acc);
    chk({name, "_q_empty"}, exp_q.size(), 0);
    sb_en = 1'b0;
  endtask

  task automatic run_stream(int n, int cnt);
    int i, guard;
    bit acc;
    sb_start(n);
    @(posedge clk);
    #1;
    i = 0;
    guard = 0;
    while (i < cnt && guard < 1000) begin
      drive_rand(n);
      @(negedge clk);
      acc = ir[n];
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    in_valid_d[n] = 1'b0;
    chk("stream_accepted", n_acc, cnt);
    drain("stream");
  endtask

  // Single op into the idle N=8 unit; returns edges from accept to out_valid.
  task automatic send_one(vec_t v, output int lat);
    @(posedge clk);
    #1;
    chk("dir_in_ready", ir[0], 1);
    in_valid_d[0] = 1'b1;
    op_d[0] = v.op;
    a_d[0] = {24'd0, v.a};
    b_d[0] = {24'd0, v.b};
    @(posedge clk);
    #1;
    in_valid_d[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  vec_t tbl[9];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    tbl[0] = '{1'b1, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0};

    in_valid_d  = '0;
    op_d        = '0;
    out_ready_d = '1;
    for (int n = 0; n < 3; n++) begin
      a_d[n] = '0;
      b_d[n] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov, 3'b000);
    chk("rst_s", s8, 0);
    chk("rst_flags", {cbw[0], ovw[0], zw[0]}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", ir, 3'b111);

    // Directed vectors, one at a time
    for (int k = 0; k < 9; k++) begin
      send_one(tbl[k], lat);
      chk("dir_latency", lat, 4);
      chk("dir_s", s8, tbl[k].s);
      chk("dir_cb", cbw[0], tbl[k].cb);
      chk("dir_ovf", ovw[0], tbl[k].ovf);
      chk("dir_zero", zw[0], tbl[k].zero);
      $display("vec %0d op=%0b a=0x%02h b=0x%02h -> s=0x%02h cb=%0b ovf=%0b zero=%0b lat=%0d",
               k, tbl[k].op, tbl[k].a, tbl[k].b, s8, cbw[0], ovw[0], zw[0], lat);
    end
    @(posedge clk);

    // Back-to-back stream at N=8
    run_stream(0, 20);
    chk("stream8_count", n_pop, 20);
    chk("stream8_back_to_back", last_pop - first_pop, 19);

    // Back-pressure: fill, freeze, then release with simultaneous accept
    sb_start(0);
    out_ready_d[0] = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      drive_rand(0);
      @(posedge clk);
      #1;
    end
    chk("stall_accepted", n_acc, 5);
    chk("stall_in_ready", ir[0], 0);
    chk("stall_out_valid", ov[0], 1);
    out_ready_d[0] = 1'b1;
    #1;
    chk("release_in_ready", ir[0], 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      drive_rand(0);
    end
    @(posedge clk);
    #1;
    in_valid_d[0] = 1'b0;
    chk("release_accepted", n_acc, 11);
    drain("stall");

    // Reset with three results in flight
    sb_start(0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      drive_rand(0);
      @(posedge clk);
      #1;
    end
    in_valid_d[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ov[0], 0);
    chk("midrst_s", s8, 0);
    chk("midrst_flags", {cbw[0], ovw[0], zw[0]}, 3'b000);
    exp_q.delete();
    n_acc = 0;
    n_pop = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    chk("midrst_no_stale", n_pop, 0);
    sb_en = 1'b0;
    send_one(tbl[0], lat);
    chk("midrst_new_latency", lat, 4);
    chk("midrst_new_s", s8, tbl[0].s);
    @(posedge clk);

    // Random streams at other widths
    run_stream(1, 20);
    chk("stream4_count", n_pop, 20);
    run_stream(2, 20);
    chk("stream32_count", n_pop, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
